// File: rtl/t07_fpu_wb_scheduler_pkg.sv
// Shared constants and types for the FPU writeback scheduler.
// Optional same-cycle operand bypass is enabled by defining T07_FPU_WB_BYPASS_EN.
package t07_fpu_pkg;

   localparam int NREGS = 32;
   localparam int XLEN  = 32;
   localparam int IDXW  = $clog2(NREGS);

   typedef enum logic {
      SRC_FPU = 1'b0,
      SRC_LD  = 1'b1
   } wb_src_t;

   typedef struct packed {
      logic [IDXW-1:0] rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

   // x0 is hardwired, so writes and pending bits for it are ignored.
   function automatic logic idx_nz(input logic [IDXW-1:0] idx);
      return (idx != {IDXW{1'b0}});
   endfunction

endpackage

// File: rtl/t07_fpu_wb_scheduler_if.sv
// Requester handshakes (FPU, FLW load) and register-file write-side bundle.
// Shared by builds with and without T07_FPU_WB_BYPASS_EN.
interface t07_fpu_wb_if import t07_fpu_pkg::*; ();

   logic            fpu_valid_i;
   logic [IDXW-1:0] fpu_rd_i;
   logic [XLEN-1:0] fpu_data_i;
   logic            fpu_ready_o;
   logic            ld_valid_i;
   logic [IDXW-1:0] ld_rd_i;
   logic [XLEN-1:0] ld_data_i;
   logic            ld_ready_o;
   logic            wb_we_o;
   logic [IDXW-1:0] wb_rd_o;
   logic [XLEN-1:0] wb_data_o;

   modport master (
      output fpu_valid_i, fpu_rd_i, fpu_data_i, ld_valid_i, ld_rd_i, ld_data_i,
      input  fpu_ready_o, ld_ready_o, wb_we_o, wb_rd_o, wb_data_o
   );

   modport slave (
      input  fpu_valid_i, fpu_rd_i, fpu_data_i, ld_valid_i, ld_rd_i, ld_data_i,
      output fpu_ready_o, ld_ready_o, wb_we_o, wb_rd_o, wb_data_o
   );

endinterface

// File: rtl/t07_fpu_wb_scheduler_scoreboard.sv
// Pending-destination scoreboard: issue sets, writeback clears, RAW/WAW hazard
// detect and sticky error on a writeback to a register that was not pending.
module t07_fpu_scoreboard import t07_fpu_pkg::*; (
   input  logic             clk,
   input  logic             nrst,
   input  logic             freeze_i,
   input  logic             iss_valid_i,
   input  logic [IDXW-1:0]  iss_rs1_i,
   input  logic [IDXW-1:0]  iss_rs2_i,
   input  logic [IDXW-1:0]  iss_rd_i,
   input  logic             iss_use_rs1_i,
   input  logic             iss_use_rs2_i,
   input  logic             iss_rd_we_i,
   input  logic             byp_rs1_i,
   input  logic             byp_rs2_i,
   input  logic             clr_en_i,
   input  logic [IDXW-1:0]  clr_idx_i,
   output logic             hazard_o,
   output logic [NREGS-1:0] pending_o,
   output logic             err_o
);

   logic [NREGS-1:0] pending_q, pending_d;
   logic             err_q, err_d;
   logic             hazard_s;
   logic             set_en_s;

   // Hazard compare and next pending/err; a set after the clear lets set win.
   always_comb begin
      hazard_s  = iss_valid_i &
                  ((iss_use_rs1_i & pending_q[iss_rs1_i] & ~byp_rs1_i) |
                   (iss_use_rs2_i & pending_q[iss_rs2_i] & ~byp_rs2_i) |
                   (iss_rd_we_i   & pending_q[iss_rd_i]));
      set_en_s  = iss_valid_i & ~hazard_s & ~freeze_i & iss_rd_we_i & idx_nz(iss_rd_i);
      pending_d = pending_q;
      err_d     = err_q;
      if (clr_en_i && idx_nz(clr_idx_i)) begin
         err_d                = err_q | ~pending_q[clr_idx_i];
         pending_d[clr_idx_i] = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (set_en_s) begin
         pending_d[iss_rd_i] = 1'b1;
      end else begin
         pending_d = pending_d;
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pending_q <= {NREGS{1'b0}};
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign hazard_o  = hazard_s;
   assign pending_o = pending_q;
   assign err_o     = err_q;

endmodule

// File: rtl/t07_fpu_wb_scheduler.sv
// FPU register-file writeback arbiter (round-robin FPU vs FLW) with hazard scoreboard.
// Define T07_FPU_WB_BYPASS_EN to add operand bypass from the registered write.
module t07_fpu_wb_scheduler import t07_fpu_pkg::*; (
   input  logic             clk,
   input  logic             nrst,
   input  logic             freeze_i,
   input  logic             iss_valid_i,
   input  logic [IDXW-1:0]  iss_rs1_i,
   input  logic [IDXW-1:0]  iss_rs2_i,
   input  logic [IDXW-1:0]  iss_rd_i,
   input  logic             iss_use_rs1_i,
   input  logic             iss_use_rs2_i,
   input  logic             iss_rd_we_i,
   output logic             hazard_o,
   t07_fpu_wb_if.slave      wb_if,
   output logic [NREGS-1:0] pending_o,
   output logic             err_o
`ifdef T07_FPU_WB_BYPASS_EN
   ,
   input  logic [XLEN-1:0]  rf_rs1_data_i,
   input  logic [XLEN-1:0]  rf_rs2_data_i,
   output logic [XLEN-1:0]  op1_o,
   output logic [XLEN-1:0]  op2_o
`endif
);

   wb_src_t         last_grant_q, last_grant_d;
   logic            wb_we_q, wb_we_d;
   logic [IDXW-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            fpu_ready_s, ld_ready_s, hs_s;
   wb_req_t         gnt_s;
   logic            byp_rs1_s, byp_rs2_s;

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      fpu_ready_s = 1'b0;
      ld_ready_s  = 1'b0;
      if (freeze_i) begin
         fpu_ready_s = 1'b0;
         ld_ready_s  = 1'b0;
      end else if (wb_if.fpu_valid_i && wb_if.ld_valid_i) begin
         fpu_ready_s = (last_grant_q == SRC_LD);
         ld_ready_s  = (last_grant_q == SRC_FPU);
      end else begin
         fpu_ready_s = wb_if.fpu_valid_i;
         ld_ready_s  = wb_if.ld_valid_i;
      end
      hs_s = fpu_ready_s | ld_ready_s;
      if (fpu_ready_s) begin
         gnt_s = '{rd: wb_if.fpu_rd_i, data: wb_if.fpu_data_i};
      end else begin
         gnt_s = '{rd: wb_if.ld_rd_i, data: wb_if.ld_data_i};
      end
   end

   // Next output register and last-grant; rd=0 completes the handshake silently.
   always_comb begin
      last_grant_d = last_grant_q;
      wb_we_d      = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      if (hs_s) begin
         last_grant_d = fpu_ready_s ? SRC_FPU : SRC_LD;
         if (idx_nz(gnt_s.rd)) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = gnt_s.rd;
            wb_data_d = gnt_s.data;
         end else begin
            wb_we_d = 1'b0;
         end
      end else begin
         wb_we_d = 1'b0;
      end
   end

   // Writeback output register and arbitration history.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last_grant_q <= SRC_LD;
         wb_we_q      <= 1'b0;
         wb_rd_q      <= {IDXW{1'b0}};
         wb_data_q    <= {XLEN{1'b0}};
      end else begin
         last_grant_q <= last_grant_d;
         wb_we_q      <= wb_we_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
      end
   end

`ifdef T07_FPU_WB_BYPASS_EN
   // A source matching the write in flight takes its data and drops its hazard.
   always_comb begin
      byp_rs1_s = wb_we_q & (wb_rd_q == iss_rs1_i) & idx_nz(iss_rs1_i);
      byp_rs2_s = wb_we_q & (wb_rd_q == iss_rs2_i) & idx_nz(iss_rs2_i);
      op1_o     = byp_rs1_s ? wb_data_q : rf_rs1_data_i;
      op2_o     = byp_rs2_s ? wb_data_q : rf_rs2_data_i;
   end
`else
   assign byp_rs1_s = 1'b0;
   assign byp_rs2_s = 1'b0;
`endif

   t07_fpu_scoreboard u_sb (
      .clk          (clk),
      .nrst         (nrst),
      .freeze_i     (freeze_i),
      .iss_valid_i  (iss_valid_i),
      .iss_rs1_i    (iss_rs1_i),
      .iss_rs2_i    (iss_rs2_i),
      .iss_rd_i     (iss_rd_i),
      .iss_use_rs1_i(iss_use_rs1_i),
      .iss_use_rs2_i(iss_use_rs2_i),
      .iss_rd_we_i  (iss_rd_we_i),
      .byp_rs1_i    (byp_rs1_s),
      .byp_rs2_i    (byp_rs2_s),
      .clr_en_i     (hs_s),
      .clr_idx_i    (gnt_s.rd),
      .hazard_o     (hazard_o),
      .pending_o    (pending_o),
      .err_o        (err_o)
   );

   assign wb_if.fpu_ready_o = fpu_ready_s;
   assign wb_if.ld_ready_o  = ld_ready_s;
   assign wb_if.wb_we_o     = wb_we_q;
   assign wb_if.wb_rd_o     = wb_rd_q;
   assign wb_if.wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_t07_fpu_wb_scheduler.sv
// Randomized and directed bench for t07_fpu_wb_scheduler against a behavioural
// model of the writeback/scoreboard rules (default build, T07_FPU_WB_BYPASS_EN undefined).
module tb_t07_fpu_wb_scheduler;
   import t07_fpu_pkg::*;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic freeze = 1'b0;
   logic iv = 1'b0, u1 = 1'b0, u2 = 1'b0, rwe = 1'b0;
   logic [4:0] rs1 = 5'd0, rs2 = 5'd0, ird = 5'd0;
   logic hazard;
   logic [NREGS-1:0] pending;
   logic err;

   t07_fpu_wb_if bus ();

   t07_fpu_wb_scheduler dut (
      .clk(clk), .nrst(nrst), .freeze_i(freeze),
      .iss_valid_i(iv), .iss_rs1_i(rs1), .iss_rs2_i(rs2), .iss_rd_i(ird),
      .iss_use_rs1_i(u1), .iss_use_rs2_i(u2), .iss_rd_we_i(rwe),
      .hazard_o(hazard), .wb_if(bus), .pending_o(pending), .err_o(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference state
   bit          m_pend[NREGS];
   bit          m_last_ld;
   bit          m_err;
   bit          m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          obs_haz, obs_fpu_gnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NREGS-1:0] pend_vec();
      logic [NREGS-1:0] v;
      for (int i = 0; i < NREGS; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
      m_last_ld = 1'b1;
      m_err = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;
   endtask

   task automatic idle_inputs();
      iv = 1'b0; u1 = 1'b0; u2 = 1'b0; rwe = 1'b0; freeze = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0; ird = 5'd0;
      bus.fpu_valid_i = 1'b0; bus.fpu_rd_i = 5'd0; bus.fpu_data_i = 32'd0;
      bus.ld_valid_i  = 1'b0; bus.ld_rd_i  = 5'd0; bus.ld_data_i  = 32'd0;
   endtask

   // One clock: check combinational outputs at negedge, advance model at posedge,
   // check registered outputs just after.
   task automatic cycle();
      bit gf, gl, hz, acc;
      logic [4:0]  r;
      logic [31:0] d;
      @(negedge clk);
      hz = iv && ((u1 && m_pend[rs1]) || (u2 && m_pend[rs2]) || (rwe && m_pend[ird]));
      gf = 1'b0; gl = 1'b0;
      if (!freeze) begin
         if (bus.fpu_valid_i && bus.ld_valid_i) begin
            gf = m_last_ld; gl = !m_last_ld;
         end else begin
            gf = bus.fpu_valid_i; gl = bus.ld_valid_i;
         end
      end
      acc = iv && !hz && !freeze && rwe && (ird != 5'd0);
      chk("fpu_ready", bus.fpu_ready_o, gf);
      chk("ld_ready", bus.ld_ready_o, gl);
      chk("ready_mutex", bus.fpu_ready_o & bus.ld_ready_o, 1'b0);
      chk("hazard", hazard, hz);
      obs_haz = hazard; obs_fpu_gnt = bus.fpu_ready_o;
      r = gf ? bus.fpu_rd_i : bus.ld_rd_i;
      d = gf ? bus.fpu_data_i : bus.ld_data_i;
      @(posedge clk);
      m_we = 1'b0;
      if (gf || gl) begin
         m_last_ld = gl;
         if (r != 5'd0) begin
            if (!m_pend[r]) m_err = 1'b1;
            m_pend[r] = 1'b0;
            m_we = 1'b1; m_rd = r; m_data = d;
         end
      end
      if (acc) m_pend[ird] = 1'b1;
      #1;
      chk("wb_we", bus.wb_we_o, m_we);
      if (m_we) begin
         chk("wb_rd", bus.wb_rd_o, m_rd);
         chk("wb_data", bus.wb_data_o, m_data);
      end
      chk("pending", pending, pend_vec());
      chk("err", err, m_err);
   endtask

   task automatic rand_inputs();
      freeze = ($urandom_range(0, 7) == 0);
      iv = $urandom_range(0, 1); u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
      rwe = $urandom_range(0, 1);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); ird = 5'($urandom_range(0, 7));
      bus.fpu_valid_i = $urandom_range(0, 1); bus.fpu_rd_i = 5'($urandom_range(0, 7));
      bus.fpu_data_i = $urandom;
      bus.ld_valid_i = $urandom_range(0, 1); bus.ld_rd_i = 5'($urandom_range(0, 7));
      bus.ld_data_i = $urandom;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_we"}, bus.wb_we_o, 1'b0);
      chk({tag, "_rd"}, bus.wb_rd_o, 5'd0);
      chk({tag, "_data"}, bus.wb_data_o, 32'd0);
      chk({tag, "_pend"}, pending, {NREGS{1'b0}});
      chk({tag, "_err"}, err, 1'b0);
   endtask

   bit prev_g;

   initial begin
      idle_inputs();
      model_reset();
      #1;
      check_reset("rst");
      chk("rst_fpu_ready", bus.fpu_ready_o, 1'b0);
      chk("rst_ld_ready", bus.ld_ready_o, 1'b0);
      chk("rst_hazard", hazard, 1'b0);
      #11 nrst = 1'b1;

      // load to x0: handshake completes, no write, no error
      bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0; bus.ld_data_i = 32'hDEAD_BEEF;
      cycle();
      chk("t5_x0_ready", obs_fpu_gnt, 1'b0);
      chk("t5_x0_we", bus.wb_we_o, 1'b0);
      chk("t5_x0_err", err, 1'b0);
      idle_inputs();

      // issue rd=5 then FPU writeback of 1.0f to rd=5
      iv = 1'b1; rwe = 1'b1; ird = 5'd5;
      cycle();
      idle_inputs();
      bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd5; bus.fpu_data_i = 32'h3F80_0000;
      cycle();
      chk("t1_we", bus.wb_we_o, 1'b1);
      chk("t1_rd", bus.wb_rd_o, 5'd5);
      chk("t1_data", bus.wb_data_o, 32'h3F80_0000);
      idle_inputs();
      cycle();
      chk("t1_we_drop", bus.wb_we_o, 1'b0);

      // RAW on rd=7: hazard holds through the writeback handshake cycle
      iv = 1'b1; rwe = 1'b1; ird = 5'd7;
      cycle();
      rwe = 1'b0; ird = 5'd0; u1 = 1'b1; rs1 = 5'd7;
      cycle();
      chk("t3_haz_pending", obs_haz, 1'b1);
      bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd7; bus.fpu_data_i = 32'h4000_0000;
      cycle();
      chk("t3_haz_wb_cycle", obs_haz, 1'b1);
      bus.fpu_valid_i = 1'b0;
      cycle();
      chk("t3_haz_clear", obs_haz, 1'b0);
      idle_inputs();

      // tie: grants must alternate
      bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd1; bus.fpu_data_i = 32'h1111_1111;
      bus.ld_valid_i  = 1'b1; bus.ld_rd_i  = 5'd2; bus.ld_data_i  = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (i > 0) chk("t2_alternate", obs_fpu_gnt, !prev_g);
         prev_g = obs_fpu_gnt;
      end
      idle_inputs();

      // writeback to non-pending rd=9 raises sticky err
      bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd9; bus.fpu_data_i = 32'h9;
      cycle();
      chk("t5_err_set", err, 1'b1);
      idle_inputs();
      cycle();
      chk("t5_err_sticky", err, 1'b1);

      // issue rd=3 together with writeback of rd=3: set wins
      iv = 1'b1; rwe = 1'b1; ird = 5'd3;
      bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd3; bus.ld_data_i = 32'h3333;
      cycle();
      chk("t4_set_wins", pending[3], 1'b1);
      idle_inputs();

      // freeze with both valid: nothing moves
      freeze = 1'b1;
      bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd3; bus.fpu_data_i = 32'hAAAA;
      bus.ld_valid_i  = 1'b1; bus.ld_rd_i  = 5'd4; bus.ld_data_i  = 32'hBBBB;
      iv = 1'b1; rwe = 1'b1; ird = 5'd6;
      for (int i = 0; i < 3; i++) cycle();
      chk("t6_frz_pend3", pending[3], 1'b1);
      chk("t6_frz_pend6", pending[6], 1'b0);
      freeze = 1'b0; iv = 1'b0;
      cycle();
      cycle();
      idle_inputs();

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         cycle();
      end

      // asynchronous reset in mid-operation
      rand_inputs();
      #2 nrst = 1'b0;
      #1;
      model_reset();
      check_reset("midrst");
      idle_inputs();
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 60; i++) begin
         rand_inputs();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
